// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF (DIF) FFT stage: delay-lane enable, butterfly select, twiddle addressing, framing.
// Optional SDF_SYNC_CHECK_EN: mid-frame in_sop resynchronises and framing violations pulse sync_err.
module sdf_stage_ctrl #(
    parameter int FFT_LEN = 1024,
    parameter int STAGE   = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    input  logic                              in_sop,
    input  logic                              flush,
    output logic                              dl_enable,
    output logic                              bf_sel,
    output logic                              pad_zero,
    output logic [$clog2(FFT_LEN / 2) - 1:0]  tw_addr,
    output logic                              tw_en,
    output logic                              out_valid,
    output logic                              out_sop,
    output logic                              sync_err,
    output logic                              busy
);
    localparam int DELAY = FFT_LEN >> (STAGE + 1);
    localparam int CW    = (DELAY > 1) ? $clog2(2 * DELAY) : 1;
    localparam int AW    = $clog2(FFT_LEN / 2);

    localparam logic [CW-1:0] CNT_FILL_LAST = CW'(DELAY - 1);
    localparam logic [CW-1:0] CNT_HALF      = CW'(DELAY);
    localparam logic [CW-1:0] CNT_MAX       = CW'(2 * DELAY - 1);
    localparam logic [CW-1:0] CNT_MASK      = CW'(DELAY - 1);

`ifdef SDF_SYNC_CHECK_EN
    localparam bit SYNC_CHECK = 1'b1;
`else
    localparam bit SYNC_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            flush_pend, flush_pend_nx;
    logic            frame_sop, frame_sop_nx;

    logic            dl_nx, bf_nx, pad_nx, tw_en_nx, ov_nx, osop_nx, serr_nx;
    logic [AW-1:0]   tw_addr_nx;
    logic            phase, resync, flush_go;

    function automatic logic [AW-1:0] tw_index(input logic [CW-1:0] c);
        logic [CW-1:0] m;
        m = c & CNT_MASK;
        return AW'(m) << STAGE;
    endfunction

    assign phase    = (cnt >= CNT_HALF);
    assign resync   = SYNC_CHECK && in_sop && (cnt != '0);
    assign flush_go = flush_pend && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            flush_pend <= 1'b0;
            frame_sop  <= 1'b0;
            dl_enable  <= 1'b0;
            bf_sel     <= 1'b0;
            pad_zero   <= 1'b0;
            tw_addr    <= '0;
            tw_en      <= 1'b0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            sync_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            flush_pend <= flush_pend_nx;
            frame_sop  <= frame_sop_nx;
            dl_enable  <= dl_nx;
            bf_sel     <= bf_nx;
            pad_zero   <= pad_nx;
            tw_addr    <= tw_addr_nx;
            tw_en      <= tw_en_nx;
            out_valid  <= ov_nx;
            out_sop    <= osop_nx;
            sync_err   <= serr_nx;
            busy       <= (state_nx != IDLE);
        end
    end

    // An accepted in_sop is sample 0 of its frame, so the counter resumes at 1.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        flush_pend_nx = flush_pend;
        frame_sop_nx  = frame_sop;
        case (state)
            IDLE: begin
                flush_pend_nx = 1'b0;
                if (in_valid && in_sop) begin
                    state_nx     = (DELAY == 1) ? RUN : FILL;
                    cnt_nx       = CW'(1);
                    frame_sop_nx = 1'b1;
                end
            end
            FILL: begin
                if (flush) begin
                    state_nx      = IDLE;
                    cnt_nx        = '0;
                    flush_pend_nx = 1'b0;
                end else if (in_valid) begin
                    if (SYNC_CHECK && in_sop) begin
                        cnt_nx       = CW'(1);
                        frame_sop_nx = 1'b1;
                        state_nx     = (DELAY == 1) ? RUN : FILL;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                        if (cnt == CNT_FILL_LAST) state_nx = RUN;
                    end
                end
            end
            RUN: begin
                if (flush) flush_pend_nx = 1'b1;
                if (in_valid) begin
                    if (resync) begin
                        cnt_nx       = CW'(1);
                        frame_sop_nx = 1'b1;
                        state_nx     = (DELAY == 1) ? RUN : FILL;
                    end else begin
                        cnt_nx = (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
                        if (cnt == '0) frame_sop_nx = in_sop;
                    end
                end else if (flush_go) begin
                    state_nx      = FLUSH;
                    cnt_nx        = CW'(1);
                    flush_pend_nx = 1'b0;
                end
            end
            FLUSH: begin
                // cnt runs 1..DELAY here; the entry edge already issued flush cycle 0.
                if (cnt == CNT_HALF) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        dl_nx      = 1'b0;
        bf_nx      = 1'b0;
        pad_nx     = 1'b0;
        tw_en_nx   = 1'b0;
        tw_addr_nx = '0;
        ov_nx      = 1'b0;
        osop_nx    = 1'b0;
        serr_nx    = 1'b0;
        case (state)
            IDLE: dl_nx = in_valid && in_sop;
            FILL: dl_nx = in_valid && !flush;
            RUN: begin
                if (in_valid) begin
                    dl_nx = 1'b1;
                    if (resync) begin
                        serr_nx = 1'b1;
                    end else begin
                        ov_nx      = 1'b1;
                        bf_nx      = phase;
                        tw_en_nx   = !phase;
                        tw_addr_nx = phase ? '0 : tw_index(cnt);
                        osop_nx    = (cnt == CNT_HALF) && frame_sop;
                    end
                end else if (flush_go) begin
                    dl_nx    = 1'b1;
                    ov_nx    = 1'b1;
                    pad_nx   = 1'b1;
                    tw_en_nx = 1'b1;
                end
            end
            FLUSH: begin
                serr_nx = SYNC_CHECK && in_valid;
                if (cnt != CNT_HALF) begin
                    dl_nx      = 1'b1;
                    ov_nx      = 1'b1;
                    pad_nx     = 1'b1;
                    tw_en_nx   = 1'b1;
                    tw_addr_nx = tw_index(cnt);
                end
            end
            default: dl_nx = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl at FFT_LEN=16, STAGE=1 (DELAY=4): vector tables through a scoreboard queue plus hand-written corner sequences.
module tb_sdf_stage_ctrl;
    localparam int FFT_LEN = 16;
    localparam int STAGE   = 1;
    localparam int AW      = 3;
`ifdef SDF_SYNC_CHECK_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sop = 1'b0;
    logic          flush = 1'b0;
    logic          dl_enable, bf_sel, pad_zero, tw_en, out_valid, out_sop, sync_err, busy;
    logic [AW-1:0] tw_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdf_stage_ctrl #(.FFT_LEN(FFT_LEN), .STAGE(STAGE)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop), .flush(flush),
        .dl_enable(dl_enable), .bf_sel(bf_sel), .pad_zero(pad_zero), .tw_addr(tw_addr),
        .tw_en(tw_en), .out_valid(out_valid), .out_sop(out_sop), .sync_err(sync_err), .busy(busy)
    );

    // Output vector bit order: dl ov osop bf pad twen addr[2:0] serr busy
    typedef struct packed {
        logic        v;
        logic        sop;
        logic        fl;
        logic [10:0] e;
    } vec_t;

    logic [10:0] sb_q[$];
    string       nm_q[$];

    function automatic logic [10:0] o(bit dl, bit ov, bit osop, bit bf, bit pad, bit twen,
                                      int addr, bit serr, bit bsy);
        return {dl, ov, osop, bf, pad, twen, 3'(addr), serr, bsy};
    endfunction

    function automatic vec_t r(logic v, logic sop, logic fl, logic [10:0] e);
        return '{v: v, sop: sop, fl: fl, e: e};
    endfunction

    function automatic logic [10:0] actual();
        return {dl_enable, out_valid, out_sop, bf_sel, pad_zero, tw_en, tw_addr, sync_err, busy};
    endfunction

    task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic sop, input logic fl,
                         input logic [10:0] e, input string nm);
        logic [10:0] want;
        string       wn;
        in_valid = v;
        in_sop   = sop;
        flush    = fl;
        sb_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty got %b want entry", nm, actual());
        end else begin
            want = sb_q.pop_front();
            wn   = nm_q.pop_front();
            check(wn, actual(), want);
        end
    endtask

    task automatic apply(input vec_t t[$], input string tag);
        foreach (t[i]) drive(t[i].v, t[i].sop, t[i].fl, t[i].e, $sformatf("%s_%0d", tag, i));
        in_valid = 1'b0;
        in_sop   = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", actual(), 11'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl_frame[$];
        vec_t tbl_a[$];
        vec_t tbl_b[$];
        logic [10:0] FILLX, OSOP, P1, GAP, SERR;

        FILLX = o(1, 0, 0, 0, 0, 0, 0, 0, 1);
        OSOP  = o(1, 1, 1, 1, 0, 0, 0, 0, 1);
        P1    = o(1, 1, 0, 1, 0, 0, 0, 0, 1);
        GAP   = o(0, 0, 0, 0, 0, 0, 0, 0, 1);
        SERR  = o(1, 0, 0, 0, 0, 0, 0, 1, 1);

        // First frame from IDLE: fill half, then sums with out_sop on sample 4.
        tbl_frame.push_back(r(1, 1, 0, FILLX));
        for (int i = 1; i < 4; i++) tbl_frame.push_back(r(1, 0, 0, FILLX));
        tbl_frame.push_back(r(1, 0, 0, OSOP));
        for (int i = 5; i < 8; i++) tbl_frame.push_back(r(1, 0, 0, P1));

        tbl_a = tbl_frame;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++)
                tbl_a.push_back(r(1, (i == 0), 0, o(1, 1, 0, 0, 0, 1, 2 * i, 0, 1)));
            tbl_a.push_back(r(1, 0, (f == 1), OSOP));
            for (int i = 5; i < 8; i++) tbl_a.push_back(r(1, 0, 0, P1));
        end
        tbl_a.push_back(r(0, 0, 0, o(1, 1, 0, 0, 1, 1, 0, 0, 1)));
        tbl_a.push_back(r(1, 0, 0, o(1, 1, 0, 0, 1, 1, 2, SC, 1)));
        tbl_a.push_back(r(0, 0, 0, o(1, 1, 0, 0, 1, 1, 4, 0, 1)));
        tbl_a.push_back(r(0, 0, 0, o(1, 1, 0, 0, 1, 1, 6, 0, 1)));
        tbl_a.push_back(r(0, 0, 0, 11'b0));
        tbl_a.push_back(r(1, 0, 0, 11'b0));

        foreach (tbl_frame[i]) begin
            tbl_b.push_back(tbl_frame[i]);
            tbl_b.push_back(r(0, 0, 0, GAP));
        end
        for (int i = 0; i < 4; i++)
            tbl_b.push_back(r(1, (i == 0), 0, o(1, 1, 0, 0, 0, 1, 2 * i, 0, 1)));
        tbl_b.push_back(r(1, 0, 0, OSOP));
        if (SC) begin
            tbl_b.push_back(r(1, 1, 0, SERR));
            for (int i = 1; i < 4; i++) tbl_b.push_back(r(1, 0, 0, FILLX));
            tbl_b.push_back(r(1, 0, 0, OSOP));
        end else begin
            tbl_b.push_back(r(1, 1, 0, P1));
            tbl_b.push_back(r(1, 0, 0, P1));
            tbl_b.push_back(r(1, 0, 0, P1));
            tbl_b.push_back(r(1, 0, 0, o(1, 1, 0, 0, 0, 1, 0, 0, 1)));
            tbl_b.push_back(r(1, 0, 0, o(1, 1, 0, 0, 0, 1, 2, 0, 1)));
        end

        do_reset();
        apply(tbl_a, "frames_flush");

        do_reset();
        apply(tbl_b, "gaps_sync");

        // Flush while filling aborts straight to IDLE.
        do_reset();
        drive(1, 1, 0, FILLX, "abort_sop");
        drive(1, 0, 0, FILLX, "abort_fill");
        drive(1, 0, 1, 11'b0, "abort_flush");
        drive(1, 0, 0, 11'b0, "abort_idle");

        // Asynchronous reset in the middle of a flush.
        do_reset();
        apply(tbl_frame, "pre_flush");
        drive(0, 0, 1, GAP, "flush_req");
        drive(0, 0, 0, o(1, 1, 0, 0, 1, 1, 0, 0, 1), "flush_k0");
        drive(0, 0, 0, o(1, 1, 0, 0, 1, 1, 2, 0, 1), "flush_k1");
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_flush", actual(), 11'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 0, 0, 11'b0, "post_reset_nosop0");
        drive(1, 0, 0, 11'b0, "post_reset_nosop1");
        drive(1, 1, 0, FILLX, "post_reset_sop");
        in_valid = 1'b0;
        in_sop   = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
